// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory load/store unit.
// Lane-steering result struct lives here so the align block and the top agree on it.
package dmem_pkg;

  typedef enum logic [2:0] {
    F3_B  = 3'b000,
    F3_H  = 3'b001,
    F3_W  = 3'b010,
    F3_BU = 3'b100,
    F3_HU = 3'b101
  } funct3_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } lsu_state_t;

  localparam int MAX_READ_LAT = 4;
  localparam int LAT_CNT_W    = $clog2(MAX_READ_LAT);

  typedef struct packed {
    logic [3:0]  wmask;
    logic [31:0] wdata;
    logic        misaligned;
  } st_lanes_t;

  function automatic logic isLegalFunct3(input logic [2:0] f3);
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
           (f3 == F3_BU) || (f3 == F3_HU);
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational byte-lane steering: store mask/data replication and load lane
// select with sign/zero extension. Access size comes from funct3[1:0].
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [2:0]  i_st_funct3,
  input  logic [1:0]  i_st_addr_lo,
  input  logic [31:0] i_st_wdata,
  output logic [3:0]  o_wmask,
  output logic [31:0] o_wdata_lanes,
  output logic        o_misaligned,
  input  logic [2:0]  i_ld_funct3,
  input  logic [1:0]  i_ld_addr_lo,
  input  logic [31:0] i_ld_raw,
  output logic [31:0] o_ld_data
);

  function automatic st_lanes_t storeLanes(input logic [2:0]  f3,
                                           input logic [1:0]  lo,
                                           input logic [31:0] wdata);
    st_lanes_t s;
    s.wmask      = 4'b0000;
    s.wdata      = wdata;
    s.misaligned = 1'b0;
    case (f3[1:0])
      2'b00: begin
        s.wmask = 4'b0001 << lo;
        s.wdata = {4{wdata[7:0]}};
      end
      2'b01: begin
        s.wmask      = 4'b0011 << {lo[1], 1'b0};
        s.wdata      = {2{wdata[15:0]}};
        s.misaligned = lo[0];
      end
      2'b10: begin
        s.wmask      = 4'b1111;
        s.misaligned = (lo != 2'b00);
      end
      default: s.wmask = 4'b0000;
    endcase
    return s;
  endfunction

  function automatic logic [31:0] loadExtend(input logic [2:0]  f3,
                                             input logic [1:0]  lo,
                                             input logic [31:0] raw);
    logic [31:0] shifted;
    logic [7:0]  b;
    logic [15:0] h;
    shifted = raw >> {lo, 3'b000};
    b       = shifted[7:0];
    h       = lo[1] ? raw[31:16] : raw[15:0];
    case (f3)
      F3_B:    return {{24{b[7]}}, b};
      F3_BU:   return {24'b0, b};
      F3_H:    return {{16{h[15]}}, h};
      F3_HU:   return {16'b0, h};
      default: return raw;
    endcase
  endfunction

  st_lanes_t w_st;

  assign w_st          = storeLanes(i_st_funct3, i_st_addr_lo, i_st_wdata);
  assign o_wmask       = w_st.wmask;
  assign o_wdata_lanes = w_st.wdata;
  assign o_misaligned  = w_st.misaligned;
  assign o_ld_data     = loadExtend(i_ld_funct3, i_ld_addr_lo, i_ld_raw);

endmodule

// File: rtl/dmem_lsu.sv
// Handshaked data memory with load/store unit: one outstanding request,
// byte-enable writes, synchronous reads with configurable extra latency.
module dmem_lsu
  import dmem_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int DEPTH    = 1024,
  parameter int READ_LAT = 1
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_req_valid,
  output logic            o_req_ready,
  input  logic            i_req_we,
  input  logic [XLEN-1:0] i_req_addr,
  input  logic [XLEN-1:0] i_req_wdata,
  input  logic [2:0]      i_req_funct3,
  output logic            o_rsp_valid,
  output logic [XLEN-1:0] o_rsp_rdata,
  output logic            o_rsp_err,
  output logic            o_busy
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  lsu_state_t           r_state;
  lsu_state_t           w_nextState;
  logic [LAT_CNT_W-1:0] r_latCnt;
  logic [2:0]           r_funct3;
  logic [1:0]           r_addrLo;
  logic [XLEN-1:0]      r_rawWord;
  logic [XLEN-1:0]      r_rspRdata;
  logic                 r_rspErr;
  logic [XLEN-1:0]      r_mem [DEPTH];

  logic                 w_accept;
  logic                 w_err;
  logic                 w_outOfRange;
  logic                 w_misaligned;
  logic [3:0]           w_wmask;
  logic [XLEN-1:0]      w_wdataLanes;
  logic [XLEN-1:0]      w_loadData;
  logic [AW-1:0]        w_wordIdx;

  dmem_lane_align u_align (
    .i_st_funct3   (i_req_funct3),
    .i_st_addr_lo  (i_req_addr[1:0]),
    .i_st_wdata    (i_req_wdata),
    .o_wmask       (w_wmask),
    .o_wdata_lanes (w_wdataLanes),
    .o_misaligned  (w_misaligned),
    .i_ld_funct3   (r_funct3),
    .i_ld_addr_lo  (r_addrLo),
    .i_ld_raw      (r_rawWord),
    .o_ld_data     (w_loadData)
  );

  assign w_accept     = i_req_valid && o_req_ready;
  assign w_outOfRange = i_req_addr[XLEN-1:2] >= (XLEN-2)'(DEPTH);
  assign w_err        = !isLegalFunct3(i_req_funct3) || w_misaligned || w_outOfRange;
  assign w_wordIdx    = i_req_addr[AW+1:2];

  // Storage array kept free of reset so it maps onto block RAM; w_accept already excludes reset.
  always_ff @(posedge i_clk) begin
    if (w_accept && !w_err) begin
      if (i_req_we) begin
        for (int i = 0; i < 4; i++) begin
          if (w_wmask[i]) r_mem[w_wordIdx][8*i +: 8] <= w_wdataLanes[8*i +: 8];
        end
      end else begin
        r_rawWord <= r_mem[w_wordIdx];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= IDLE;
    else         r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    unique case (r_state)
      IDLE:    if (w_accept) w_nextState = (i_req_we || w_err) ? RESP : WAIT;
      WAIT:    if (r_latCnt == '0) w_nextState = RESP;
      RESP:    w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  always_comb begin
    o_req_ready = (r_state == IDLE) && !i_reset;
    o_rsp_valid = (r_state == RESP);
    o_busy      = (r_state != IDLE);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_latCnt <= '0;
      r_funct3 <= '0;
      r_addrLo <= '0;
    end else if (w_accept) begin
      r_latCnt <= LAT_CNT_W'(READ_LAT - 1);
      r_funct3 <= i_req_funct3;
      r_addrLo <= i_req_addr[1:0];
    end else if (r_state == WAIT && r_latCnt != '0) begin
      r_latCnt <= r_latCnt - 1'b1;
    end
  end

  // Stores and faults answer straight from the accept edge; loads settle on leaving WAIT.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_rspRdata <= '0;
      r_rspErr   <= 1'b0;
    end else if (w_accept && (i_req_we || w_err)) begin
      r_rspRdata <= '0;
      r_rspErr   <= w_err;
    end else if (r_state == WAIT && r_latCnt == '0) begin
      r_rspRdata <= w_loadData;
      r_rspErr   <= 1'b0;
    end
  end

  assign o_rsp_rdata = r_rspRdata;
  assign o_rsp_err   = r_rspErr;

endmodule

// File: tb/tb_dmem_lsu.sv
// Scoreboard bench for dmem_lsu: two instances (READ_LAT 1 and 3) see the same
// request stream; a word-array model predicts data, faults and response cycle.
module tb_dmem_lsu;

  localparam int DEPTH = 64;
  localparam int LAT_A = 1;
  localparam int LAT_B = 3;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } exp_t;

  logic        clk       = 1'b0;
  logic        reset     = 1'b1;
  logic        reqValid  = 1'b0;
  logic        reqWe     = 1'b0;
  logic [31:0] reqAddr   = '0;
  logic [31:0] reqWdata  = '0;
  logic [2:0]  reqFunct3 = '0;

  logic        rdyA, rdyB, vldA, vldB, errA, errB, busyA, busyB;
  logic [31:0] rdA, rdB;

  exp_t        qA[$];
  exp_t        qB[$];
  exp_t        eA, eB;
  bit          popA, popB;
  logic [31:0] model [DEPTH];
  logic [2:0]  legalF3 [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

  int cyc    = 0;
  int checks = 0;
  int errors = 0;
  bit monOn  = 1'b0;

  dmem_lsu #(.XLEN(32), .DEPTH(DEPTH), .READ_LAT(LAT_A)) dutA (
    .i_clk(clk), .i_reset(reset), .i_req_valid(reqValid), .o_req_ready(rdyA),
    .i_req_we(reqWe), .i_req_addr(reqAddr), .i_req_wdata(reqWdata),
    .i_req_funct3(reqFunct3), .o_rsp_valid(vldA), .o_rsp_rdata(rdA),
    .o_rsp_err(errA), .o_busy(busyA)
  );

  dmem_lsu #(.XLEN(32), .DEPTH(DEPTH), .READ_LAT(LAT_B)) dutB (
    .i_clk(clk), .i_reset(reset), .i_req_valid(reqValid), .o_req_ready(rdyB),
    .i_req_we(reqWe), .i_req_addr(reqAddr), .i_req_wdata(reqWdata),
    .i_req_funct3(reqFunct3), .o_rsp_valid(vldB), .o_rsp_rdata(rdB),
    .o_rsp_err(errB), .o_busy(busyB)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkValue(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s: got %h want %h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // Reference model: byte-addressed view of a word array, faults from alignment/range/funct3.
  function automatic void modelAccess(input logic we, input logic [31:0] addr,
                                      input logic [31:0] wdata, input logic [2:0] f3,
                                      output logic [31:0] rdata, output logic err);
    int          size;
    int          idx;
    int          sh;
    logic [31:0] laneMask;
    logic [31:0] w;
    size  = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    err   = !(f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101}) ||
            ((addr % size) != 0) || ((addr >> 2) >= DEPTH);
    rdata = '0;
    if (err) return;
    idx = int'(addr >> 2);
    sh  = 8 * int'(addr % 4);
    if (we) begin
      laneMask   = (size == 1) ? 32'hFF : (size == 2) ? 32'hFFFF : 32'hFFFF_FFFF;
      model[idx] = (model[idx] & ~(laneMask << sh)) | ((wdata & laneMask) << sh);
    end else begin
      w = model[idx] >> sh;
      if (size == 1)      rdata = f3[2] ? 32'(w[7:0])  : 32'($signed(w[7:0]));
      else if (size == 2) rdata = f3[2] ? 32'(w[15:0]) : 32'($signed(w[15:0]));
      else                rdata = w;
    end
  endfunction

  task automatic applyStimulus(input logic we, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [2:0] f3);
    int          waitCnt;
    int          accCyc;
    logic [31:0] rd;
    logic        er;
    exp_t        e;
    waitCnt = 0;
    do begin
      @(posedge clk);
      #2;
      waitCnt++;
    end while (!(rdyA && rdyB) && waitCnt < 50);
    if (!(rdyA && rdyB)) begin
      checks++;
      errors++;
      $display("[TB] FAIL ready timeout: got rdyA=%0b rdyB=%0b want 1", rdyA, rdyB);
      return;
    end
    reqValid  = 1'b1;
    reqWe     = we;
    reqAddr   = addr;
    reqWdata  = wdata;
    reqFunct3 = f3;
    accCyc    = cyc;
    @(posedge clk);
    modelAccess(we, addr, wdata, f3, rd, er);
    e.rdata = rd;
    e.err   = er;
    e.cyc   = accCyc + ((we || er) ? 1 : LAT_A + 1);
    qA.push_back(e);
    e.cyc   = accCyc + ((we || er) ? 1 : LAT_B + 1);
    qB.push_back(e);
    #2;
    reqValid = 1'b0;
    reqWdata = $urandom;
  endtask

  task automatic applyReset(input int n);
    reset = 1'b1;
    @(posedge clk);
    qA.delete();
    qB.delete();
    monOn = 1'b1;
    repeat (n - 1) @(posedge clk);
    #2;
    reset = 1'b0;
    checkValue("A reset rdata", rdA, 32'h0);
    checkValue("B reset rdata", rdB, 32'h0);
    checkValue("A reset err", 32'(errA), 32'h0);
    checkValue("B reset err", 32'(errB), 32'h0);
  endtask

  task automatic checkOutput(input string tag, input logic vld, input logic rdy,
                             input logic busy, input logic [31:0] rd, input logic er,
                             input bit has, input exp_t e, output bit pop);
    bit expValid;
    expValid = has && (e.cyc == cyc);
    pop      = has && (e.cyc <= cyc);
    checkValue({tag, " rsp_valid"}, 32'(vld), 32'(expValid));
    checkValue({tag, " busy"}, 32'(busy), 32'(has));
    checkValue({tag, " req_ready"}, 32'(rdy), 32'(!has && !reset));
    if (expValid) begin
      checkValue({tag, " rsp_rdata"}, rd, e.rdata);
      checkValue({tag, " rsp_err"}, 32'(er), 32'(e.err));
    end
  endtask

  always @(negedge clk) begin
    if (monOn) begin
      if (qA.size() > 0) eA = qA[0];
      if (qB.size() > 0) eB = qB[0];
      checkOutput("A", vldA, rdyA, busyA, rdA, errA, qA.size() > 0, eA, popA);
      checkOutput("B", vldB, rdyB, busyB, rdB, errB, qB.size() > 0, eB, popB);
      if (popA) void'(qA.pop_front());
      if (popB) void'(qB.pop_front());
    end
  end

  initial begin
    logic [2:0]  rf3;
    logic [31:0] ra;
    applyReset(2);

    for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, 32'(i * 4), $urandom, 3'b010);

    applyStimulus(1'b1, 32'h10, 32'hDEADBEEF, 3'b010);
    applyStimulus(1'b0, 32'h10, 32'h0, 3'b010);
    applyStimulus(1'b1, 32'h10, 32'h11223344, 3'b010);
    applyStimulus(1'b1, 32'h13, 32'h00000080, 3'b000);
    applyStimulus(1'b0, 32'h10, 32'h0, 3'b010);
    applyStimulus(1'b0, 32'h13, 32'h0, 3'b000);
    applyStimulus(1'b0, 32'h13, 32'h0, 3'b100);
    applyStimulus(1'b1, 32'h20, 32'h0, 3'b010);
    applyStimulus(1'b1, 32'h22, 32'h00008001, 3'b001);
    applyStimulus(1'b0, 32'h22, 32'h0, 3'b001);
    applyStimulus(1'b0, 32'h20, 32'h0, 3'b101);
    applyStimulus(1'b0, 32'h12, 32'h0, 3'b010);
    applyStimulus(1'b1, 32'h21, 32'h0000BEEF, 3'b001);
    applyStimulus(1'b0, 32'h20, 32'h0, 3'b010);
    applyStimulus(1'b1, 32'(4 * DEPTH), 32'h12345678, 3'b010);
    applyStimulus(1'b0, 32'h0, 32'h0, 3'b011);
    applyStimulus(1'b0, 32'(4 * DEPTH - 4), 32'h0, 3'b010);

    for (int n = 0; n < 200; n++) begin
      rf3 = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) != 0) rf3 = legalF3[$urandom_range(0, 4)];
      ra = 32'($urandom_range(0, 4 * DEPTH + 15));
      if ($urandom_range(0, 1) == 1) ra[1:0] = 2'b00;
      applyStimulus(1'($urandom_range(0, 1)), ra, $urandom, rf3);
    end

    // Load dropped by a reset one cycle after accept, then a store offered only during reset.
    applyStimulus(1'b0, 32'h10, 32'h0, 3'b010);
    applyReset(2);
    repeat (4) @(posedge clk);
    #2;
    reqValid  = 1'b1;
    reqWe     = 1'b1;
    reqAddr   = 32'h10;
    reqWdata  = 32'hCAFEF00D;
    reqFunct3 = 3'b010;
    applyReset(2);
    reqValid = 1'b0;
    repeat (4) @(posedge clk);
    applyStimulus(1'b0, 32'h10, 32'h0, 3'b010);
    applyStimulus(1'b1, 32'h8, 32'hA5A5A5A5, 3'b010);
    applyStimulus(1'b0, 32'h8, 32'h0, 3'b010);

    repeat (10) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
